fht_but_pipe: RTL and testbench
===============================

// Module: fht_but_pipe
// PURPOSE
//  Parametrised, pipelined successor of the FHT 2-point butterfly.
//  Computes M = (cos*X1 + sin*X2)/2^(W_BIT-1), then Y0 = X0+M and Y1 = X0-M.
//  Per-sample optional /2 scaling, selectable rounding, output saturation and overflow flags.
//  Sits between the FHT bank RAM readers and the write-back path; accepts one butterfly per clock.
// PARAMETERS
//  D_BIT   18  data word width (signed two's complement)
//  W_BIT   16  twiddle width (signed); unity = 2^(W_BIT-1)-1
//  ROUND   1   0 = truncate (floor), 1 = round-half-up at each right shift
//  SAT     1   1 = saturate Y0/Y1 to D_BIT range; 0 = wrap (flags still computed)
// PORTS
//  iCLK        in   1      clock
//  iRESET      in   1      synchronous reset, active-high
//  iVALID      in   1      input sample valid
//  iHOLD       in   1      pipeline stall: all stage registers keep their value
//  iSCALE      in   1      1 = halve outputs (Y/2), travels with the sample
//  iX_0        in   D_BIT  direct input
//  iX_1        in   D_BIT  cos-weighted input
//  iX_2        in   D_BIT  sin-weighted input
//  iSIN        in   W_BIT  twiddle sine
//  iCOS        in   W_BIT  twiddle cosine
//  iCLR_OVF    in   1      clear sticky overflow flag
//  oVALID      out  1      output sample valid
//  oY_0        out  D_BIT  X0 + M (scaled/saturated)
//  oY_1        out  D_BIT  X0 - M (scaled/saturated)
//  oOVF        out  1      this output sample clipped (qualified by oVALID)
//  oOVF_STICKY out  1      any clip since reset/clear
// BEHAVIOUR
//  - Reset (sync, high): all valid bits, oY_0, oY_1, oOVF, oOVF_STICKY <= 0. Applies mid-flight; in-flight samples are dropped.
//  - Latency fixed at 3 enabled cycles; throughput 1/clk when iHOLD=0.
//  - S1: P1 = iCOS*iX_1 and P2 = iSIN*iX_2 (D_BIT+W_BIT signed each); X0, iSCALE and iVALID delayed.
//  - S2: S = P1+P2 (D_BIT+W_BIT+1); M = S >>> (W_BIT-1), kept at D_BIT+2 bits.
//        ROUND=1: add 2^(W_BIT-2) before the shift.
//  - S3: A = X0+M and B = X0-M at D_BIT+3 bits.
//        If scale: shift each >>>1 (ROUND=1: add 1 before the shift).
//        Clip to [-2^(D_BIT-1), 2^(D_BIT-1)-1]; oOVF=1 if either word clipped.
//        SAT=0: low D_BIT bits are output, but oOVF is still asserted.
//  - iHOLD=1: no register (data, valid, flags) changes. Inputs presented during hold are ignored.
//  - oOVF_STICKY sets when oVALID & oOVF are registered.
//        Same-cycle iCLR_OVF and a new overflow: the set wins.
//        iCLR_OVF is honoured even while iHOLD=1.
//  - Invalid samples propagate data but never raise oOVF/oOVF_STICKY; oOVF is 0 whenever oVALID=0.
//  - iRESET overrides iHOLD and iCLR_OVF.
// STRUCTURE
//  - common_types_pkg gets:
//      typedef fht_data_t (signed [D_BIT-1:0]);
//      typedef fht_coef_t (signed [W_BIT-1:0]);
//      constants FHT_MAX_D = 2^(D_BIT-1)-1 and FHT_MIN_D;
//      function sat_d() shared with the future radix-4 butterfly.
//  - One sub-module, fht_round_shift: signed arithmetic right shift by a parameter amount, with optional round-half-up.
//    It is instantiated in S2 and, twice, in S3.
//  - Everything else stays inline.
// TESTING
//  Default params (D_BIT=18, W_BIT=16, ROUND=1, SAT=1) unless noted.
//  1. X0=1000, X1=2000, X2=0, cos=16384, sin=0, scale=1
//       -> 3 clk later: oVALID=1, Y0=1000, Y1=0, oOVF=0.
//  2. X0=0, X1=1, X2=0, cos=16384, sin=0, scale=0
//       -> ROUND=1: Y0=1, Y1=-1; ROUND=0: Y0=0, Y1=0.
//  3. X0=X1=131071, X2=0, cos=32767, sin=0, scale=0
//       -> Y0=131071 (clipped), Y1=4, oOVF=1, oOVF_STICKY=1.
//     Then pulse iCLR_OVF -> sticky=0.
//  4. 20 back-to-back random samples, with iHOLD=1 for 2 cycles mid-stream
//       -> outputs match the float model (|err| <= 1 LSB), in order.
//       -> oVALID frozen during hold; no sample lost or duplicated.
//  5. iRESET=1 for 1 clk while 2 samples are in flight
//       -> next cycle: oVALID=0, Y0=Y1=0, sticky=0; the dropped samples never appear.
//  6. 8 special angles (0, 45, ..., 315 deg), with X1 and X2 at full scale in ±sign combos
//       -> matches the reference model; scale=1 never clips.

Source files
------------

// File: rtl/fht_but_pipe_pkg.sv
// Shared FHT butterfly types, word limits and the output saturation helper.
// Holds the default word widths used by the butterfly family and the
// saturation function that the radix-2 and future radix-4 butterflies share.
package fht_but_pipe_pkg;

  localparam int unsigned FHT_D_BIT = 18;
  localparam int unsigned FHT_W_BIT = 16;

  typedef logic signed [FHT_D_BIT-1:0] fht_data_t;
  typedef logic signed [FHT_W_BIT-1:0] fht_coef_t;

  localparam fht_data_t FHT_MAX_D = {1'b0, {(FHT_D_BIT-1){1'b1}}};
  localparam fht_data_t FHT_MIN_D = {1'b1, {(FHT_D_BIT-1){1'b0}}};

  // Limits sign-extended to the 3-bit-wider butterfly sum width
  localparam logic signed [FHT_D_BIT+2:0] FHT_MAX_X = {3'b000, FHT_MAX_D};
  localparam logic signed [FHT_D_BIT+2:0] FHT_MIN_X = {3'b111, FHT_MIN_D};

  // Clamp a butterfly sum to the data word range
  function automatic fht_data_t sat_d(input logic signed [FHT_D_BIT+2:0] x);
    if (x > FHT_MAX_X) begin
      return FHT_MAX_D;
    end
    if (x < FHT_MIN_X) begin
      return FHT_MIN_D;
    end
    return FHT_D_BIT'(x);
  endfunction

endpackage

// File: rtl/fht_but_pipe_if.sv
// Sample/result bundle between the bank RAM readers, the butterfly and write-back.
// master: drives iVALID/iHOLD/iSCALE/iX_*/iSIN/iCOS/iCLR_OVF, reads o*.
// slave : the butterfly; reads i*, drives oVALID/oY_0/oY_1/oOVF/oOVF_STICKY.
interface fht_but_pipe_if #(
  parameter int unsigned D_BIT = 18,
  parameter int unsigned W_BIT = 16
);

  logic                    iVALID;
  logic                    iHOLD;
  logic                    iSCALE;
  logic signed [D_BIT-1:0] iX_0;
  logic signed [D_BIT-1:0] iX_1;
  logic signed [D_BIT-1:0] iX_2;
  logic signed [W_BIT-1:0] iSIN;
  logic signed [W_BIT-1:0] iCOS;
  logic                    iCLR_OVF;
  logic                    oVALID;
  logic signed [D_BIT-1:0] oY_0;
  logic signed [D_BIT-1:0] oY_1;
  logic                    oOVF;
  logic                    oOVF_STICKY;

  modport master (
    output iVALID, iHOLD, iSCALE, iX_0, iX_1, iX_2, iSIN, iCOS, iCLR_OVF,
    input  oVALID, oY_0, oY_1, oOVF, oOVF_STICKY
  );

  modport slave (
    input  iVALID, iHOLD, iSCALE, iX_0, iX_1, iX_2, iSIN, iCOS, iCLR_OVF,
    output oVALID, oY_0, oY_1, oOVF, oOVF_STICKY
  );

endinterface

// File: rtl/fht_round_shift.sv
// Combinational signed arithmetic right shift by SHIFT bits with optional
// round-half-up (adds 2^(SHIFT-1) first). One guard bit absorbs the rounding
// carry; the result is truncated to OUT_W, which the caller sizes to fit.
// Ports: din (IN_W signed) -> dout_c (OUT_W signed). SHIFT must be >= 1.
module fht_round_shift #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 1,
  parameter int unsigned ROUND = 1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout_c
);

  localparam int unsigned SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] HALF =
    (ROUND != 0) ? (SUM_W'(1) << (SHIFT - 1)) : '0;

  logic signed [SUM_W-1:0] sum_c;

  always_comb begin
    sum_c  = SUM_W'(din) + HALF;
    dout_c = OUT_W'(sum_c >>> SHIFT);
  end

endmodule

// File: rtl/fht_but_pipe.sv
// Pipelined FHT 2-point butterfly, 3-cycle latency, one sample per clock.
//   M  = round(cos*X1 + sin*X2) / 2^(W_BIT-1)
//   Y0 = X0 + M, Y1 = X0 - M, optionally halved, then saturated (SAT=1) or wrapped.
// Ports: iCLK, iRESET (sync, active-high), bus (slave side of fht_but_pipe_if).
// iHOLD freezes every stage; iCLR_OVF still clears the sticky flag during hold.
module fht_but_pipe
  import fht_but_pipe_pkg::*;
#(
  parameter int unsigned D_BIT = FHT_D_BIT,
  parameter int unsigned W_BIT = FHT_W_BIT,
  parameter int unsigned ROUND = 1,
  parameter int unsigned SAT   = 1
) (
  input logic           iCLK,
  input logic           iRESET,
  fht_but_pipe_if.slave bus
);

  localparam int unsigned P_W = D_BIT + W_BIT;
  localparam int unsigned S_W = P_W + 1;
  localparam int unsigned M_W = D_BIT + 2;
  localparam int unsigned A_W = D_BIT + 3;
  localparam logic signed [A_W-1:0] MAX_A = A_W'((longint'(1) <<< (D_BIT - 1)) - 1);
  localparam logic signed [A_W-1:0] MIN_A = A_W'(-(longint'(1) <<< (D_BIT - 1)));

  // Stage 1: products
  logic                    vld_s1_q, vld_s1_d, scale_s1_q, scale_s1_d;
  logic signed [D_BIT-1:0] x0_s1_q, x0_s1_d;
  logic signed [P_W-1:0]   p1_q, p1_d, p2_q, p2_d;
  // Stage 2: scaled twiddle product M
  logic                    vld_s2_q, vld_s2_d, scale_s2_q, scale_s2_d;
  logic signed [D_BIT-1:0] x0_s2_q, x0_s2_d;
  logic signed [M_W-1:0]   m_q, m_d;
  // Stage 3: outputs
  logic                    vld_q, vld_d, ovf_q, ovf_d, sticky_q, sticky_d;
  logic signed [D_BIT-1:0] y0_q, y0_d, y1_q, y1_d;

  logic signed [S_W-1:0]   s_c;
  logic signed [M_W-1:0]   m_c;
  logic signed [A_W-1:0]   a_c, b_c, a_half_c, b_half_c, a_sel_c, b_sel_c;
  logic                    clip_a_c, clip_b_c;
  logic signed [D_BIT-1:0] y0_c, y1_c;

  // Product sum and the Q(W_BIT-1) rescale
  always_comb begin
    s_c = S_W'(p1_q) + S_W'(p2_q);
  end

  fht_round_shift #(.IN_W(S_W), .OUT_W(M_W), .SHIFT(W_BIT - 1), .ROUND(ROUND)) u_rs_m (
    .din    (s_c),
    .dout_c (m_c)
  );

  // Butterfly sums at full width; the optional /2 uses the rounding shifter
  always_comb begin
    a_c = A_W'(x0_s2_q) + A_W'(m_q);
    b_c = A_W'(x0_s2_q) - A_W'(m_q);
  end

  fht_round_shift #(.IN_W(A_W), .OUT_W(A_W), .SHIFT(1), .ROUND(ROUND)) u_rs_a (
    .din    (a_c),
    .dout_c (a_half_c)
  );

  fht_round_shift #(.IN_W(A_W), .OUT_W(A_W), .SHIFT(1), .ROUND(ROUND)) u_rs_b (
    .din    (b_c),
    .dout_c (b_half_c)
  );

  // Clip detection always runs; SAT only selects clamp versus wrap
  always_comb begin
    a_sel_c  = scale_s2_q ? a_half_c : a_c;
    b_sel_c  = scale_s2_q ? b_half_c : b_c;
    clip_a_c = (a_sel_c > MAX_A) || (a_sel_c < MIN_A);
    clip_b_c = (b_sel_c > MAX_A) || (b_sel_c < MIN_A);
    y0_c     = D_BIT'(a_sel_c);
    y1_c     = D_BIT'(b_sel_c);
    if (SAT != 0) begin
      if (a_sel_c > MAX_A)      y0_c = D_BIT'(MAX_A);
      else if (a_sel_c < MIN_A) y0_c = D_BIT'(MIN_A);
      if (b_sel_c > MAX_A)      y1_c = D_BIT'(MAX_A);
      else if (b_sel_c < MIN_A) y1_c = D_BIT'(MIN_A);
    end
  end

  // Next-state: every stage advances only when not held
  always_comb begin
    vld_s1_d   = vld_s1_q;
    scale_s1_d = scale_s1_q;
    x0_s1_d    = x0_s1_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    vld_s2_d   = vld_s2_q;
    scale_s2_d = scale_s2_q;
    x0_s2_d    = x0_s2_q;
    m_d        = m_q;
    vld_d      = vld_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    ovf_d      = ovf_q;
    sticky_d   = sticky_q;
    if (!bus.iHOLD) begin
      vld_s1_d   = bus.iVALID;
      scale_s1_d = bus.iSCALE;
      x0_s1_d    = bus.iX_0;
      p1_d       = P_W'(bus.iCOS) * P_W'(bus.iX_1);
      p2_d       = P_W'(bus.iSIN) * P_W'(bus.iX_2);
      vld_s2_d   = vld_s1_q;
      scale_s2_d = scale_s1_q;
      x0_s2_d    = x0_s1_q;
      m_d        = m_c;
      vld_d      = vld_s2_q;
      y0_d       = y0_c;
      y1_d       = y1_c;
      ovf_d      = vld_s2_q && (clip_a_c || clip_b_c);
    end
    // Clear first so a same-cycle new overflow wins
    if (bus.iCLR_OVF) sticky_d = 1'b0;
    if (!bus.iHOLD && ovf_d) sticky_d = 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      vld_s1_q   <= 1'b0;
      scale_s1_q <= 1'b0;
      x0_s1_q    <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      vld_s2_q   <= 1'b0;
      scale_s2_q <= 1'b0;
      x0_s2_q    <= '0;
      m_q        <= '0;
      vld_q      <= 1'b0;
      y0_q       <= '0;
      y1_q       <= '0;
      ovf_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      vld_s1_q   <= vld_s1_d;
      scale_s1_q <= scale_s1_d;
      x0_s1_q    <= x0_s1_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      vld_s2_q   <= vld_s2_d;
      scale_s2_q <= scale_s2_d;
      x0_s2_q    <= x0_s2_d;
      m_q        <= m_d;
      vld_q      <= vld_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      ovf_q      <= ovf_d;
      sticky_q   <= sticky_d;
    end
  end

  assign bus.oVALID      = vld_q;
  assign bus.oY_0        = y0_q;
  assign bus.oY_1        = y1_q;
  assign bus.oOVF        = ovf_q;
  assign bus.oOVF_STICKY = sticky_q;

endmodule

// File: tb/tb_fht_but_pipe.sv
// Bench for fht_but_pipe: driver pushes model results into a scoreboard queue
// tagged with the enabled-edge index they are due on; a monitor pops and compares.
module tb_fht_but_pipe;

  localparam int unsigned D_BIT = 18;
  localparam int unsigned W_BIT = 16;
  localparam int unsigned ROUND = 1;
  localparam int unsigned SAT   = 1;

  logic iCLK   = 1'b0;
  logic iRESET = 1'b1;

  always #5 iCLK = ~iCLK;

  fht_but_pipe_if #(.D_BIT(D_BIT), .W_BIT(W_BIT)) bus ();

  fht_but_pipe #(.D_BIT(D_BIT), .W_BIT(W_BIT), .ROUND(ROUND), .SAT(SAT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus)
  );

  typedef struct {
    longint y0;
    longint y1;
    bit     ovf;
    int     due;
    string  name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_idx = 0;

  // Monitor-side expected state
  bit   m_hold, m_rst, m_clr;
  bit   exp_v, exp_ovf, exp_sticky;
  exp_t last_e, cur_e;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  // Floor division for a positive divisor
  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if (((a % b) != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint sat_model(input longint v, output bit c);
    longint mx, mn, w;
    mx = (longint'(1) <<< (D_BIT - 1)) - 1;
    mn = -mx - 1;
    c  = (v > mx) || (v < mn);
    if (!c) return v;
    if (SAT != 0) return (v > mx) ? mx : mn;
    w = v & ((longint'(1) <<< D_BIT) - 1);
    if (w > mx) w = w - (longint'(1) <<< D_BIT);
    return w;
  endfunction

  function automatic exp_t model(input longint x0, input longint x1, input longint x2,
                                 input longint c, input longint s, input bit sc);
    exp_t   e;
    longint m, a, b, rh;
    bit     ca, cb;
    rh = (ROUND != 0) ? (longint'(1) <<< (W_BIT - 2)) : 0;
    m  = fdiv(c * x1 + s * x2 + rh, longint'(1) <<< (W_BIT - 1));
    a  = x0 + m;
    b  = x0 - m;
    if (sc) begin
      a = fdiv(a + ((ROUND != 0) ? 1 : 0), 2);
      b = fdiv(b + ((ROUND != 0) ? 1 : 0), 2);
    end
    e.y0   = sat_model(a, ca);
    e.y1   = sat_model(b, cb);
    e.ovf  = ca | cb;
    e.due  = 0;
    e.name = "";
    return e;
  endfunction

  task automatic drive(input longint x0, input longint x1, input longint x2,
                       input longint c, input longint s, input bit sc,
                       input bit v, input bit hold, input bit clr, input string nm);
    exp_t e;
    @(negedge iCLK);
    bus.iX_0     = D_BIT'(x0);
    bus.iX_1     = D_BIT'(x1);
    bus.iX_2     = D_BIT'(x2);
    bus.iCOS     = W_BIT'(c);
    bus.iSIN     = W_BIT'(s);
    bus.iSCALE   = sc;
    bus.iVALID   = v;
    bus.iHOLD    = hold;
    bus.iCLR_OVF = clr;
    if (v && !hold && !iRESET) begin
      e      = model(x0, x1, x2, c, s, sc);
      e.due  = edge_idx + 3;
      e.name = nm;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  function automatic longint rnd_d();
    return longint'($urandom_range(0, (1 << D_BIT) - 1)) - (longint'(1) <<< (D_BIT - 1));
  endfunction

  function automatic longint rnd_w();
    return longint'($urandom_range(0, (1 << W_BIT) - 1)) - (longint'(1) <<< (W_BIT - 1));
  endfunction

  // Monitor: classify each edge as reset, hold or enabled, then compare
  initial begin : monitor
    forever begin
      @(posedge iCLK);
      m_hold = bus.iHOLD;
      m_rst  = iRESET;
      m_clr  = bus.iCLR_OVF;
      #1;
      if (m_rst) begin
        exp_v      = 1'b0;
        exp_ovf    = 1'b0;
        exp_sticky = 1'b0;
        chk("rst_valid",  longint'(bus.oVALID), 0);
        chk("rst_y0",     longint'(bus.oY_0), 0);
        chk("rst_y1",     longint'(bus.oY_1), 0);
        chk("rst_ovf",    longint'(bus.oOVF), 0);
        chk("rst_sticky", longint'(bus.oOVF_STICKY), 0);
      end else if (m_hold) begin
        if (m_clr) exp_sticky = 1'b0;
        chk("hold_valid", longint'(bus.oVALID), longint'(exp_v));
        chk("hold_ovf",   longint'(bus.oOVF), longint'(exp_ovf));
        if (exp_v) begin
          chk("hold_y0", longint'(bus.oY_0), last_e.y0);
          chk("hold_y1", longint'(bus.oY_1), last_e.y1);
        end
        chk("hold_sticky", longint'(bus.oOVF_STICKY), longint'(exp_sticky));
      end else begin
        edge_idx++;
        if (m_clr) exp_sticky = 1'b0;
        if ((sb.size() > 0) && (sb[0].due == edge_idx)) begin
          cur_e   = sb.pop_front();
          last_e  = cur_e;
          exp_v   = 1'b1;
          exp_ovf = cur_e.ovf;
          if (cur_e.ovf) exp_sticky = 1'b1;
          chk({cur_e.name, "_valid"}, longint'(bus.oVALID), 1);
          chk({cur_e.name, "_y0"},    longint'(bus.oY_0), cur_e.y0);
          chk({cur_e.name, "_y1"},    longint'(bus.oY_1), cur_e.y1);
          chk({cur_e.name, "_ovf"},   longint'(bus.oOVF), longint'(cur_e.ovf));
        end else begin
          exp_v   = 1'b0;
          exp_ovf = 1'b0;
          chk("idle_valid", longint'(bus.oVALID), 0);
          chk("idle_ovf",   longint'(bus.oOVF), 0);
        end
        chk("sticky", longint'(bus.oOVF_STICKY), longint'(exp_sticky));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  localparam int COS_T [8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};
  localparam int SIN_T [8] = '{0, 23170, 32767, 23170, 0, -23170, -32767, -23170};

  initial begin : stim
    longint x1v, x2v;
    bus.iVALID = 1'b0; bus.iHOLD = 1'b0; bus.iSCALE = 1'b0; bus.iCLR_OVF = 1'b0;
    bus.iX_0 = '0; bus.iX_1 = '0; bus.iX_2 = '0; bus.iSIN = '0; bus.iCOS = '0;
    repeat (2) @(negedge iCLK);
    iRESET = 1'b0;
    idle(2);

    // Directed cases; clear lands on the same edge as the clipped result
    drive(1000, 2000, 0, 16384, 0, 1'b1, 1'b1, 1'b0, 1'b0, "t1");
    drive(0, 1, 0, 16384, 0, 1'b0, 1'b1, 1'b0, 1'b0, "t2");
    drive(131071, 131071, 0, 32767, 0, 1'b0, 1'b1, 1'b0, 1'b0, "t3");
    idle(1);
    drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "clr_same");
    idle(2);
    drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "clr_hold");
    idle(4);

    // Random back-to-back stream with a 2-cycle hold in the middle
    for (int i = 0; i < 22; i++) begin
      drive(rnd_d(), rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'($urandom_range(0, 1)),
            1'b1, (i == 10) || (i == 11), 1'b0, "rnd");
    end
    idle(4);

    // Reset with two samples in flight, after sticky has been set
    drive(131071, 131071, 0, 32767, 0, 1'b0, 1'b1, 1'b0, 1'b0, "t5ovf");
    idle(4);
    drive(rnd_d(), rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'b0, 1'b1, 1'b0, 1'b0, "drop");
    drive(rnd_d(), rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'b0, 1'b1, 1'b0, 1'b0, "drop");
    @(negedge iCLK);
    iRESET = 1'b1;
    bus.iHOLD = 1'b1;
    bus.iVALID = 1'b1;
    sb.delete();
    @(negedge iCLK);
    iRESET = 1'b0;
    bus.iHOLD = 1'b0;
    bus.iVALID = 1'b0;
    idle(5);

    // Special angles with full-scale X1/X2 sign combinations
    for (int k = 0; k < 8; k++) begin
      for (int sg = 0; sg < 4; sg++) begin
        x1v = ((sg % 2) == 1) ? -131072 : 131071;
        x2v = (sg >= 2) ? -131072 : 131071;
        drive(rnd_d() / 4, x1v, x2v, COS_T[k], SIN_T[k], 1'b0, 1'b1, 1'b0, 1'b0, "ang");
        drive(rnd_d() / 4, x1v, x2v, COS_T[k], SIN_T[k], 1'b1, 1'b1, 1'b0, 1'b0, "angs");
      end
    end
    idle(6);

    chk("sb_empty", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
